// File: rtl/axis_conv_in_slice_pkg.sv
// Shared conv-input definitions: tuser bit indices, skid-slice state encoding
// and a helper that builds the tuser strobe mask. Used by the input pipe, this
// slice and the conv engine.
package axis_conv_in_slice_pkg;

   localparam int unsigned TUSER_WIDTH_CONV_IN = 11;

   // conv tuser bit positions
   localparam int unsigned I_KERNEL_W_1      = 0;
   localparam int unsigned I_IS_TOP_BLOCK    = 3;
   localparam int unsigned I_IS_BOTTOM_BLOCK = 4;
   localparam int unsigned I_IS_COLS_1_K2    = 6;
   localparam int unsigned I_IS_ACC_LAST     = 8;

   // Two-entry skid buffer occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   // One-hot OR of the four per-beat strobe positions
   function automatic logic [31:0] strobe_mask(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
      return (32'd1 << a) | (32'd1 << b) | (32'd1 << c) | (32'd1 << d);
   endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Generic fully registered two-entry AXI-Stream skid register.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   s_valid/s_ready  upstream handshake (s_ready is a flop)
//   s_data           upstream payload, WIDTH bits
//   m_valid/m_ready  downstream handshake (m_valid is a flop)
//   m_data           downstream payload, driven straight from the main register
module axis_skid_reg
   import axis_conv_in_slice_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   skid_state_e      state_q;
   skid_state_e      state_d;
   logic             in_hs;
   logic             out_hs;
   logic             ld_main_in;
   logic             ld_main_skid;
   logic             ld_skid;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   assign in_hs  = s_valid & s_ready;
   assign out_hs = m_valid & m_ready;
   assign m_data = main_q;

   // Next-state and register-load decode
   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_hs) begin
               ld_main_in = 1'b1;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (in_hs && out_hs) begin
               ld_main_in = 1'b1;
            end else if (in_hs) begin
               ld_skid = 1'b1;
               state_d = FULL;
            end else if (out_hs) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // s_ready is low here, so only the drain can happen
            if (out_hs) begin
               ld_main_skid = 1'b1;
               state_d      = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State, handshake flops and storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         // ready looks ahead at next state so it never waits on m_ready
         s_ready <= (state_d != FULL);
         m_valid <= (state_d != EMPTY);
         if (ld_main_in) begin
            main_q <= s_data;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid) begin
            skid_q <= s_data;
         end
      end
   end

endmodule

// File: rtl/axis_conv_in_slice.sv
// Registered slice between the input pipe's merged stream and the conv engine.
// Carries two pixel words, one weight word, tuser and tlast per beat and clears
// the per-beat tuser strobes whenever the output is idle.
// Ports:
//   aclk, aresetn                      clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tlast/tuser   upstream handshake and sideband
//   s_axis_pixels_1/2_tdata            upstream pixel streams, PIX_W each
//   s_axis_weights_tdata               upstream weights, WGT_W
//   m_axis_*                           downstream mirror; tuser strobe-masked
module axis_conv_in_slice #(
   parameter  int unsigned UNITS               = 2,
   parameter  int unsigned WORD_WIDTH          = 8,
   parameter  int unsigned CORES               = 4,
   parameter  int unsigned KERNEL_W_MAX        = 3,
   parameter  int unsigned TUSER_WIDTH_CONV_IN = axis_conv_in_slice_pkg::TUSER_WIDTH_CONV_IN,
   parameter  int unsigned I_IS_TOP_BLOCK      = axis_conv_in_slice_pkg::I_IS_TOP_BLOCK,
   parameter  int unsigned I_IS_BOTTOM_BLOCK   = axis_conv_in_slice_pkg::I_IS_BOTTOM_BLOCK,
   parameter  int unsigned I_IS_COLS_1_K2      = axis_conv_in_slice_pkg::I_IS_COLS_1_K2,
   parameter  int unsigned I_IS_ACC_LAST       = axis_conv_in_slice_pkg::I_IS_ACC_LAST,
   localparam int unsigned PIX_W               = WORD_WIDTH * UNITS,
   localparam int unsigned WGT_W               = WORD_WIDTH * CORES * KERNEL_W_MAX
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tvalid,
   input  logic                           s_axis_tlast,
   input  logic [TUSER_WIDTH_CONV_IN-1:0] s_axis_tuser,
   input  logic [PIX_W-1:0]               s_axis_pixels_1_tdata,
   input  logic [PIX_W-1:0]               s_axis_pixels_2_tdata,
   input  logic [WGT_W-1:0]               s_axis_weights_tdata,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   output logic [TUSER_WIDTH_CONV_IN-1:0] m_axis_tuser,
   output logic [PIX_W-1:0]               m_axis_pixels_1_tdata,
   output logic [PIX_W-1:0]               m_axis_pixels_2_tdata,
   output logic [WGT_W-1:0]               m_axis_weights_tdata
);

   import axis_conv_in_slice_pkg::*;

   localparam int unsigned BEAT_W = 2 * PIX_W + WGT_W + TUSER_WIDTH_CONV_IN + 1;

   localparam logic [TUSER_WIDTH_CONV_IN-1:0] STROBE_MASK = TUSER_WIDTH_CONV_IN'(
      strobe_mask(I_IS_TOP_BLOCK, I_IS_BOTTOM_BLOCK, I_IS_COLS_1_K2, I_IS_ACC_LAST));

   logic [BEAT_W-1:0]              s_beat;
   logic [BEAT_W-1:0]              m_beat;
   logic [TUSER_WIDTH_CONV_IN-1:0] beat_tuser;

   assign s_beat = {s_axis_tlast, s_axis_tuser, s_axis_weights_tdata,
                    s_axis_pixels_2_tdata, s_axis_pixels_1_tdata};

   axis_skid_reg #(
      .WIDTH (BEAT_W)
   ) u_skid (
      .clk     (aclk),
      .rst_n   (aresetn),
      .s_valid (s_axis_tvalid),
      .s_ready (s_axis_tready),
      .s_data  (s_beat),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  (m_beat)
   );

   assign {m_axis_tlast, beat_tuser, m_axis_weights_tdata,
           m_axis_pixels_2_tdata, m_axis_pixels_1_tdata} = m_beat;

   // Strobes must read zero while idle; the held beat may still carry them
   assign m_axis_tuser = m_axis_tvalid ? beat_tuser : (beat_tuser & ~STROBE_MASK);

endmodule

// File: doc/axis_conv_in_slice.md
# axis_conv_in_slice

Fully registered two-entry AXI-Stream skid slice inserted between the input pipe's merged output and the conv engine. It breaks the combinational `tvalid`/`tready` path created by joining the pixel and weight streams, and carries one joint beat per cycle: two pixel words, one weight word, `tuser` and `tlast`. It also guarantees that the per-beat `tuser` strobe bits are zero whenever the output is not valid.

## Interface
- `UNITS`, default 2: pixel words per pixel stream.
- `WORD_WIDTH`, default 8: bits per word.
- `CORES`, default 4: weight cores.
- `KERNEL_W_MAX`, default 3: maximum kernel width.
- `TUSER_WIDTH_CONV_IN`, default 11: conv tuser width.
- `I_IS_TOP_BLOCK`, default 3; `I_IS_BOTTOM_BLOCK`, default 4; `I_IS_COLS_1_K2`, default 6; `I_IS_ACC_LAST`, default 8: indices of the strobe bits.
- Derived localparams:
  - `PIX_W = WORD_WIDTH*UNITS`
  - `WGT_W = WORD_WIDTH*CORES*KERNEL_W_MAX`
  - `BEAT_W = 2*PIX_W + WGT_W + TUSER_WIDTH_CONV_IN + 1`

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tready` out 1: registered ready.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tlast` in 1: input last beat.
- `s_axis_tuser` in `TUSER_WIDTH_CONV_IN`: input conv tuser.
- `s_axis_pixels_1_tdata` in `PIX_W`: pixel stream 1.
- `s_axis_pixels_2_tdata` in `PIX_W`: pixel stream 2.
- `s_axis_weights_tdata` in `WGT_W`: weights.
- `m_axis_tready` in 1: conv engine ready.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tlast` out 1: output last beat.
- `m_axis_tuser` out `TUSER_WIDTH_CONV_IN`: output tuser, strobe-masked.
- `m_axis_pixels_1_tdata` out `PIX_W`: pixel stream 1.
- `m_axis_pixels_2_tdata` out `PIX_W`: pixel stream 2.
- `m_axis_weights_tdata` out `WGT_W`: weights.

## Operation
- **Storage.** Two `BEAT_W` registers: main `M` drives all `m_axis_*` outputs; skid `S` holds overflow.
- **Handshakes.**
  - `in = s_axis_tvalid & s_axis_tready`
  - `out = m_axis_tvalid & m_axis_tready`
- **State machine** (2-bit state):
  - EMPTY: if `in`, `M <= s`, go to ONE.
  - ONE:
    - `in & out`: `M <= s`, stay in ONE.
    - `in` only: `S <= s`, go to FULL.
    - `out` only: go to EMPTY.
    - neither: hold.
  - FULL: if `out`, `M <= S`, go to ONE. `in` is impossible in FULL because `s_axis_tready` is 0.
- **Output valid.** `m_axis_tvalid = (state != EMPTY)`, driven from a flop.
- **Input ready.** `s_axis_tready` is a flop with next value `(next_state != FULL)`. It never depends combinationally on `m_axis_tready`.
- **Strobe masking.** `m_axis_tuser` equals `M.tuser` with bits `I_IS_TOP_BLOCK`, `I_IS_BOTTOM_BLOCK`, `I_IS_COLS_1_K2` and `I_IS_ACC_LAST` ANDed with `m_axis_tvalid`. All other tuser bits pass unmasked.
- **Ordering.** Beats leave in arrival order. No beat is dropped, duplicated or reordered.
- **Transparency.** `tlast` and all data fields are not interpreted.
- **Payload.** No arithmetic; payload is copied bit-exact.

## Timing
- **Latency.** A beat accepted at edge k appears on `m_axis_*` after edge k, i.e. it is accepted downstream at edge k+1 at the earliest. One cycle.
- **Throughput.** 1 beat/cycle sustained while `m_axis_tready` = 1.
- **Output stability.** While `m_axis_tvalid` = 1 and `m_axis_tready` = 0, all `m_axis_*` outputs are stable.
- **Backpressure.** `m_axis_tready` falling costs at most one extra stored beat (into `S`); `s_axis_tready` drops on the following edge.
- **Recovery from FULL.** A FULL-state `out` reasserts `s_axis_tready` on the same edge (next state ONE).
- **Reset.** While `aresetn` = 0, asynchronously:
  - state = EMPTY.
  - `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0.
  - `m_axis_tuser` = 0 and all tdata = 0; `M` and `S` are reset to 0.
- **After reset.** `s_axis_tready` rises at the first `aclk` edge after `aresetn` deasserts.
- **Reset mid-operation.** Any held beats are discarded; there is no partial-beat recovery.

## Structure
- Shared package entries:
  - conv tuser index constants (`I_IS_*`, `I_KERNEL_W_1`) and `TUSER_WIDTH_CONV_IN`.
  - the state encoding (`EMPTY`, `ONE`, `FULL`).
- The input pipe and the conv engine use the same package.
- Pack the payload into one `BEAT_W` vector: `{tlast, tuser, weights, pixels_2, pixels_1}`.
- Implement the buffering in one generic sub-module, `axis_skid_reg #(WIDTH)`. The top level adds only the strobe masking and the port unpacking.

## Test plan
- **Reset then stream.** Reset, then present 8 beats with `m_axis_tready`=1 and `pixels_1_tdata` = 0x0100+i. Required:
  - `s_axis_tready` = 0 during reset and 1 one edge after release.
  - Outputs appear one cycle after acceptance, one per cycle, in order.
- **Backpressure.** Drop `m_axis_tready` for 5 cycles mid-stream. Required:
  - Exactly one beat enters `S`.
  - `s_axis_tready` falls the next edge and `m_axis_*` is stable throughout.
  - After release, beats resume in order with none lost.
- **Random handshakes.** Random `s_axis_tvalid` and `m_axis_tready` (50%) over 10,000 beats. Required: the scoreboard matches bit-exact and `s_axis_tready` has no combinational dependence on `m_axis_tready`.
- **Strobe masking.** Input `tuser` = 0x7FF, then the stream idles. Required:
  - `m_axis_tuser` = 0x7FF while valid.
  - Once `m_axis_tvalid` = 0, bits 3, 4, 6 and 8 read 0, i.e. `m_axis_tuser` = 0x6A7.
- **Reset mid-operation.** Assert `aresetn` = 0 asynchronously while in FULL. Required:
  - `m_axis_tvalid`, `s_axis_tready`, `m_axis_tuser` and all tdata go to 0 immediately.
  - After release, the first output is the first beat sent after reset.
- **tlast passthrough.** Packet of 21 beats with `tlast` on beat 20 under random backpressure. Required: `m_axis_tlast` = 1 only on output beat 20.
